// File: rtl/count_display.sv
// rtl/count_display.sv - 5-bit count to two-digit BCD converter with multiplexed 7-segment drive
//
// Ports:
//   clk    in   single clock, rising edge
//   rstn   in   synchronous active-low reset
//   value  in   [4:0] binary count 0..31
//   tens   out  [3:0] latched BCD tens digit 0..3
//   ones   out  [3:0] latched BCD ones digit 0..9
//   upd    out  one-cycle pulse when tens/ones take new values
//   busy   out  high while a conversion is in progress
//   seg    out  [6:0] segment drive, bit0=a .. bit6=g
//   an     out  [1:0] one-hot digit enable, 01=ones, 10=tens
module count_display #(
    parameter int SCAN_DIV   = 4,
    parameter int BLANK_LZ   = 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] value,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       upd,
    output logic       busy,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t      state, state_nx;
    logic [4:0]  shreg, shreg_nx;
    logic [4:0]  cap, cap_nx;
    logic [4:0]  last, last_nx;
    logic [7:0]  scratch, scratch_nx;
    logic [7:0]  adj;
    logic [2:0]  iter, iter_nx;
    logic        pend, pend_nx;
    logic [3:0]  tens_nx, ones_nx;
    logic        upd_nx;

    logic [DW-1:0] div;
    logic          sel;
    logic          sel_eff;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;
    logic [6:0]    seg_raw;
    logic [1:0]    an_raw;

    // pend forces one conversion after reset so outputs reflect value even if it equals last
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            shreg   <= '0;
            cap     <= '0;
            last    <= '0;
            scratch <= '0;
            iter    <= '0;
            pend    <= 1'b1;
            tens    <= '0;
            ones    <= '0;
            upd     <= 1'b0;
        end else begin
            state   <= state_nx;
            shreg   <= shreg_nx;
            cap     <= cap_nx;
            last    <= last_nx;
            scratch <= scratch_nx;
            iter    <= iter_nx;
            pend    <= pend_nx;
            tens    <= tens_nx;
            ones    <= ones_nx;
            upd     <= upd_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        cap_nx     = cap;
        last_nx    = last;
        scratch_nx = scratch;
        iter_nx    = iter;
        pend_nx    = pend;
        tens_nx    = tens;
        ones_nx    = ones;
        upd_nx     = 1'b0;
        adj        = scratch;
        case (state)
            IDLE: begin
                if (value != last || pend) begin
                    shreg_nx   = value;
                    cap_nx     = value;
                    scratch_nx = '0;
                    iter_nx    = '0;
                    pend_nx    = 1'b0;
                    state_nx   = SHIFT;
                end
            end
            SHIFT: begin
                // double-dabble: correct nibbles >= 5 before each shift
                if (scratch[3:0] >= 4'd5) adj[3:0] = scratch[3:0] + 4'd3;
                if (scratch[7:4] >= 4'd5) adj[7:4] = scratch[7:4] + 4'd3;
                {scratch_nx, shreg_nx} = {adj, shreg} << 1;
                iter_nx = iter + 3'd1;
                if (iter == 3'd4) state_nx = LATCH;
            end
            LATCH: begin
                tens_nx  = scratch[7:4];
                ones_nx  = scratch[3:0];
                last_nx  = cap;
                upd_nx   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // free-running scan divider, independent of the converter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div <= '0;
            sel <= 1'b0;
        end else if (div == DW'(SCAN_DIV - 1)) begin
            div <= '0;
            sel <= ~sel;
        end else begin
            div <= div + 1'b1;
        end
    end

    // during reset the display shows a zero on the ones digit
    assign sel_eff = sel & rstn;
    assign digit   = !rstn ? 4'd0 : (sel_eff ? tens : ones);

    always_comb begin
        case (digit)
            4'd0:    seg_dec = 7'h3F;
            4'd1:    seg_dec = 7'h06;
            4'd2:    seg_dec = 7'h5B;
            4'd3:    seg_dec = 7'h4F;
            4'd4:    seg_dec = 7'h66;
            4'd5:    seg_dec = 7'h6D;
            4'd6:    seg_dec = 7'h7D;
            4'd7:    seg_dec = 7'h07;
            4'd8:    seg_dec = 7'h7F;
            4'd9:    seg_dec = 7'h6F;
            default: seg_dec = 7'h00;
        endcase
    end

    assign seg_raw = (BLANK_LZ != 0 && sel_eff && tens == 4'd0) ? 7'h00 : seg_dec;
    assign an_raw  = sel_eff ? 2'b10 : 2'b01;
    assign seg     = (ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    assign an      = (ACTIVE_LOW != 0) ? ~an_raw  : an_raw;

endmodule

// File: tb/tb_count_display.sv
// tb/tb_count_display.sv - scoreboard bench for count_display
module tb_count_display;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] value;
    logic [3:0] tens, ones, tens_al, ones_al;
    logic       upd, busy, upd_al, busy_al;
    logic [6:0] seg, seg_al;
    logic [1:0] an, an_al;

    always #5 clk = ~clk;

    count_display #(.SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rstn(rstn), .value(value), .tens(tens), .ones(ones),
        .upd(upd), .busy(busy), .seg(seg), .an(an)
    );

    count_display #(.SCAN_DIV(4), .BLANK_LZ(1), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rstn(rstn), .value(value), .tens(tens_al), .ones(ones_al),
        .upd(upd_al), .busy(busy_al), .seg(seg_al), .an(an_al)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         upd_total = 0;
    int         upd_cyc_last = 0;
    int         upd_cyc_prev = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_e;
    logic [1:0] seq[16];
    int         bcnt, first, s, n, j, found;
    logic [1:0] exp_an;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_upd(input string tag, output int cnt);
        int start;
        start = upd_total;
        cnt = 0;
        while (upd_total == start && cnt < 30) begin
            step();
            cnt++;
        end
        if (upd_total == start) check({tag, "_timeout"}, upd_total - start, 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn === 1'b1 && upd === 1'b1) begin
            upd_total++;
            upd_cyc_prev = upd_cyc_last;
            upd_cyc_last = cyc;
            check("sb_has_entry", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_e = sb.pop_front();
                check("upd_tens", tens, exp_e[7:4]);
                check("upd_ones", ones, exp_e[3:0]);
            end
            check("al_upd", upd_al, 1);
            check("al_ones", ones_al, ones);
        end
    end

    initial begin
        rstn  = 1'b0;
        value = 5'd4;
        repeat (3) step();
        check("rst_tens", tens, 0);
        check("rst_ones", ones, 0);
        check("rst_upd", upd, 0);
        check("rst_busy", busy, 0);
        check("rst_an", an, 1);
        check("rst_seg", seg, 'h3F);
        check("rst_an_al", an_al, 2);
        check("rst_seg_al", seg_al, 'h40);
        check("rst_busy_al", busy_al, 0);
        check("rst_tens_al", tens_al, 0);

        // release with value=4 held: force triggers a single conversion
        sb.push_back({4'd0, 4'd4});
        rstn  = 1'b1;
        bcnt  = 0;
        first = 0;
        s     = upd_total;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (busy) bcnt++;
            if (first == 0 && upd_total != s) first = i;
        end
        check("busy_cycles", bcnt, 6);
        check("latency", first, 7);
        check("upd_once", upd_total - s, 1);

        for (int v = 0; v < 32; v++) begin
            value = 5'(v);
            sb.push_back({4'(v / 10), 4'(v % 10)});
            wait_upd("sweep", n);
        end

        // 31 -> 0 wrap
        value = 5'd0;
        sb.push_back(8'h00);
        wait_upd("wrap", n);
        found = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (found == 0 && an == 2'b01) begin
                check("wrap_seg", seg, 'h3F);
                found = 1;
            end
        end
        check("wrap_an_seen", found, 1);

        s = upd_total;
        repeat (20) step();
        check("no_extra_upd", upd_total - s, 0);

        // change during SHIFT is ignored until next IDLE
        value = 5'd12;
        sb.push_back({4'd1, 4'd2});
        repeat (3) step();
        value = 5'd25;
        sb.push_back({4'd2, 4'd5});
        wait_upd("pair1", n);
        wait_upd("pair2", n);
        check("upd_gap", upd_cyc_last - upd_cyc_prev, 7);

        // scan multiplexing with tens=0 ones=4
        value = 5'd4;
        sb.push_back({4'd0, 4'd4});
        wait_upd("scan_load", n);
        for (int i = 0; i < 16; i++) begin
            step();
            seq[i] = an;
            if (an == 2'b01) begin
                check("scan_seg_ones", seg, 'h66);
                check("scan_seg_ones_al", seg_al, 'h19);
                check("scan_an_al_ones", an_al, 2);
            end else begin
                check("scan_an_tens", an, 2);
                check("scan_seg_tens", seg, 0);
                check("scan_seg_tens_al", seg_al, 'h7F);
                check("scan_an_al_tens", an_al, 1);
            end
        end
        j = 1;
        while (j < 5 && seq[j] == seq[j-1]) j++;
        check("scan_edge_found", int'(j < 5), 1);
        if (j < 5) begin
            for (int k = 0; k < 12; k++) begin
                exp_an = (((k / 4) % 2) == 0) ? seq[j] : seq[j-1];
                check("scan_run", seq[j+k], exp_an);
            end
        end

        // reset during SHIFT aborts without upd
        value = 5'd20;
        step();
        step();
        s    = upd_total;
        rstn = 1'b0;
        step();
        check("abort_tens", tens, 0);
        check("abort_ones", ones, 0);
        check("abort_busy", busy, 0);
        check("abort_upd", upd, 0);
        check("abort_no_upd", upd_total - s, 0);
        sb.push_back({4'd2, 4'd0});
        rstn = 1'b1;
        wait_upd("post_reset", n);

        // force converts even when value equals the reset value of last
        rstn  = 1'b0;
        value = 5'd0;
        step();
        sb.push_back(8'h00);
        rstn = 1'b1;
        wait_upd("force_zero", n);
        check("force_zero_ones", ones, 0);

        repeat (4) step();
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
